serial_bit_streamer: RTL and testbench
======================================

// Module: serial_bit_streamer
// PURPOSE
//  Upstream stimulus stage for the serial pattern detectors (e.g. 101 detector).
//  Accepts a parallel word over a valid/ready handshake and emits it MSB-first
//  as a 1-bit stream, one bit every CLK_PER_BIT clocks.
//  ser_x drives the detector's X input; ser_valid/done frame the stream.
// PARAMETERS
//  WIDTH        8   bits per word; legal range >= 2
//  CLK_PER_BIT  1   clocks each bit is held on ser_x; legal range >= 1
//  IDLE_LEVEL   0   value driven on ser_x when no bit is being sent (1'b0/1'b1)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset
//  load_valid  in   1      load_data is valid
//  load_ready  out  1      block can accept a word; transfer = load_valid & load_ready
//  load_data   in   WIDTH  word to serialize
//  ser_x       out  1      serial bit, MSB first
//  ser_valid   out  1      high while ser_x carries a frame bit
//  busy        out  1      frame in progress (= ~load_ready)
//  done        out  1      1-cycle pulse on the last clock of the last bit
// BEHAVIOUR
//  - Reset (async assert, sync release), all values forced immediately:
//    state=IDLE, ser_x=IDLE_LEVEL, ser_valid=0, busy=0, load_ready=1, done=0,
//    shift register and counters cleared.
//  - FSM states:
//    IDLE  : load_ready=1. Transfer at edge k -> SHIFT, shreg<=load_data,
//            bit_cnt<=0, div_cnt<=0.
//    SHIFT : ser_x=shreg[MSB], ser_valid=1. div_cnt counts 0..CLK_PER_BIT-1.
//            At wrap: shift left 1, bit_cnt++.
//            At wrap with bit_cnt==FRAME-1: done=1 that cycle, -> IDLE.
//    PAR   : present only with the macro; see CONFIGURATION.
//  - Latency: first bit appears in the cycle after the accepting edge.
//    Frame occupies exactly FRAME*CLK_PER_BIT cycles. FRAME=WIDTH, or WIDTH+1
//    with parity.
//  - Back-to-back: load_ready rises in the first IDLE cycle after done.
//    A held load_valid is accepted there, giving exactly 1 idle cycle
//    (ser_valid=0, ser_x=IDLE_LEVEL) between frames.
//  - load_valid while busy: ignored, no storage; load_data is sampled only on transfer.
//  - All outputs registered except load_ready/busy, which decode state.
//  - Counters sized $clog2 of their range +1; no wrap beyond the terminal count.
//  - Reset mid-frame: frame aborted, no done pulse, ser_x=IDLE_LEVEL at once.
// CONFIGURATION
//  SERIAL_PARITY_EN defined: after the last data bit, FSM enters PAR for
//    CLK_PER_BIT cycles. ser_x = ^word (even parity), ser_valid=1.
//    done pulses on the last PAR cycle. FRAME = WIDTH+1.
//  undefined: no PAR state; done pulses on the last data bit. FRAME = WIDTH.
// TESTING
//  1 W=8,CPB=1: load 8'hA0 -> ser_x cycles1..8 = 1,0,1,0,0,0,0,0; done at cycle8;
//    load_ready=1 at cycle9
//  2 W=8,CPB=3: load 8'b101xxxxx -> each bit held 3 cycles; ser_valid high 24 cycles
//  3 load_valid held, words 8'h05 then 8'hFF -> 1-cycle gap;
//    ser_x=IDLE_LEVEL, ser_valid=0 in gap
//  4 load_valid pulsed mid-frame with 8'h00 -> ignored; current frame bits unchanged
//  5 rst_n low at bit 4 of 8'hFF -> ser_x=IDLE_LEVEL, ser_valid=0 same cycle, no done;
//    load_ready=1 after release
//  6 SERIAL_PARITY_EN, W=8: load 8'h07 -> 8 data bits then ser_x=1; done on 9th bit
//    (8'h03 -> parity 0)

Source files
------------

// File: rtl/serial_bit_streamer.sv
// rtl/serial_bit_streamer.sv - parallel word to MSB-first 1-bit stream with valid/ready load
// Optional even-parity bit after the data bits: define SERIAL_PARITY_EN.
module serial_bit_streamer #(
    parameter int   WIDTH       = 8,
    parameter int   CLK_PER_BIT = 1,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_x,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

`ifdef SERIAL_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int BW = $clog2(FRAME) + 1;
    localparam int DW = $clog2(CLK_PER_BIT) + 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             ser_x_q, ser_x_d;
    logic             ser_valid_q, ser_valid_d;
    logic             done_q, done_d;
    logic             div_wrap;
`ifdef SERIAL_PARITY_EN
    logic             par_q, par_d;
`endif

    assign load_ready = (state_q == IDLE);
    assign busy       = ~load_ready;
    assign div_wrap   = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
`ifdef SERIAL_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d   = SHIFT;
                    shreg_d   = load_data;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
`ifdef SERIAL_PARITY_EN
                    par_d     = ^load_data;
`endif
                end
            end
            SHIFT: begin
                if (div_wrap) begin
                    div_cnt_d = '0;
                    shreg_d   = shreg_q << 1;
                    if (bit_cnt_q == DATA_LAST) begin
`ifdef SERIAL_PARITY_EN
                        state_d   = PAR;
                        bit_cnt_d = bit_cnt_q + BW'(1);
`else
                        state_d   = IDLE;
                        bit_cnt_d = '0;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
`ifdef SERIAL_PARITY_EN
            PAR: begin
                if (div_wrap) begin
                    state_d   = IDLE;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
`endif
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                div_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with
    // the cycle the state machine is actually in, without a cycle of lag.
    always_comb begin
        ser_valid_d = (state_d != IDLE);
        ser_x_d     = IDLE_LEVEL;
        done_d      = 1'b0;
        if (state_d == SHIFT) begin
            ser_x_d = shreg_d[WIDTH-1];
        end
`ifdef SERIAL_PARITY_EN
        if (state_d == PAR) begin
            ser_x_d = par_d;
            done_d  = (div_cnt_d == DIV_LAST);
        end
`else
        if (state_d == SHIFT) begin
            done_d = (div_cnt_d == DIV_LAST) && (bit_cnt_d == DATA_LAST);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            ser_x_q     <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SERIAL_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            ser_x_q     <= ser_x_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
`ifdef SERIAL_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign ser_x     = ser_x_q;
    assign ser_valid = ser_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_bit_streamer.sv
// tb/tb_serial_bit_streamer.sv - directed self-checking bench for serial_bit_streamer
module tb_serial_bit_streamer;

`ifdef SERIAL_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lv1, lv3;
    logic [7:0] ld1, ld3;
    logic       lr1, sx1, sv1, bz1, dn1;
    logic       lr3, sx3, sv3, bz3, dn3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_bit_streamer #(.WIDTH(8), .CLK_PER_BIT(1), .IDLE_LEVEL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(lr1),
        .load_data(ld1), .ser_x(sx1), .ser_valid(sv1), .busy(bz1), .done(dn1)
    );

    serial_bit_streamer #(.WIDTH(8), .CLK_PER_BIT(3), .IDLE_LEVEL(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv3), .load_ready(lr3),
        .load_data(ld3), .ser_x(sx3), .ser_valid(sv3), .busy(bz3), .done(dn3)
    );

    // Bit idx of a frame: data MSB first, then even parity of the word.
    function automatic logic exp_bit(input logic [7:0] w, input int idx);
        if (idx < 8) return w[7-idx];
        return ^w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        lv1 = 1'b0; ld1 = 8'h00; lv3 = 1'b0; ld3 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (sx1 !== 1'b0) begin n_err++; $display("FAIL reset_ser_x1 got %b want 0", sx1); end
        n_cmp++; if (sv1 !== 1'b0) begin n_err++; $display("FAIL reset_ser_valid1 got %b want 0", sv1); end
        n_cmp++; if (dn1 !== 1'b0) begin n_err++; $display("FAIL reset_done1 got %b want 0", dn1); end
        n_cmp++; if (lr1 !== 1'b1) begin n_err++; $display("FAIL reset_load_ready1 got %b want 1", lr1); end
        n_cmp++; if (bz1 !== 1'b0) begin n_err++; $display("FAIL reset_busy1 got %b want 0", bz1); end
        n_cmp++; if (sx3 !== 1'b1) begin n_err++; $display("FAIL reset_ser_x3 got %b want 1", sx3); end
        n_cmp++; if (sv3 !== 1'b0) begin n_err++; $display("FAIL reset_ser_valid3 got %b want 0", sv3); end
        n_cmp++; if (lr3 !== 1'b1) begin n_err++; $display("FAIL reset_load_ready3 got %b want 1", lr3); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic(input logic [7:0] w);
        @(posedge clk); #1;
        lv1 = 1'b1; ld1 = w;
        @(negedge clk);
        n_cmp++; if (lr1 !== 1'b1) begin n_err++; $display("FAIL basic_ready_pre got %b want 1", lr1); end
        @(posedge clk); #1;
        lv1 = 1'b0; ld1 = 8'h5A;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            n_cmp++; if (sx1 !== exp_bit(w, c-1)) begin n_err++; $display("FAIL basic_ser_x c=%0d got %b want %b", c, sx1, exp_bit(w, c-1)); end
            n_cmp++; if (sv1 !== 1'b1) begin n_err++; $display("FAIL basic_ser_valid c=%0d got %b want 1", c, sv1); end
            n_cmp++; if (dn1 !== (c == FRAME)) begin n_err++; $display("FAIL basic_done c=%0d got %b want %b", c, dn1, (c == FRAME)); end
            n_cmp++; if (bz1 !== 1'b1) begin n_err++; $display("FAIL basic_busy c=%0d got %b want 1", c, bz1); end
        end
        @(negedge clk);
        n_cmp++; if (lr1 !== 1'b1) begin n_err++; $display("FAIL basic_ready_after got %b want 1", lr1); end
        n_cmp++; if (sv1 !== 1'b0) begin n_err++; $display("FAIL basic_valid_after got %b want 0", sv1); end
        n_cmp++; if (sx1 !== 1'b0) begin n_err++; $display("FAIL basic_idle_x got %b want 0", sx1); end
        n_cmp++; if (dn1 !== 1'b0) begin n_err++; $display("FAIL basic_done_after got %b want 0", dn1); end
    endtask

    task automatic test_cpb3(input logic [7:0] w);
        int nvalid = 0;
        int ndone = 0;
        @(posedge clk); #1;
        lv3 = 1'b1; ld3 = w;
        @(posedge clk); #1;
        lv3 = 1'b0;
        for (int c = 1; c <= FRAME*3 + 2; c++) begin
            @(negedge clk);
            if (sv3) nvalid++;
            if (dn3) ndone++;
            if (c <= FRAME*3) begin
                n_cmp++; if (sx3 !== exp_bit(w, (c-1)/3)) begin n_err++; $display("FAIL cpb3_ser_x c=%0d got %b want %b", c, sx3, exp_bit(w, (c-1)/3)); end
                n_cmp++; if (dn3 !== (c == FRAME*3)) begin n_err++; $display("FAIL cpb3_done c=%0d got %b want %b", c, dn3, (c == FRAME*3)); end
            end else begin
                n_cmp++; if (sx3 !== 1'b1) begin n_err++; $display("FAIL cpb3_idle_x c=%0d got %b want 1", c, sx3); end
                n_cmp++; if (lr3 !== 1'b1) begin n_err++; $display("FAIL cpb3_ready c=%0d got %b want 1", c, lr3); end
            end
        end
        n_cmp++; if (nvalid != FRAME*3) begin n_err++; $display("FAIL cpb3_valid_cycles got %0d want %0d", nvalid, FRAME*3); end
        n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL cpb3_done_count got %0d want 1", ndone); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wa = 8'h05;
        logic [7:0] wb = 8'hFF;
        @(posedge clk); #1;
        lv1 = 1'b1; ld1 = wa;
        @(posedge clk); #1;
        ld1 = wb;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            n_cmp++; if (sx1 !== exp_bit(wa, c-1)) begin n_err++; $display("FAIL b2b_a_ser_x c=%0d got %b want %b", c, sx1, exp_bit(wa, c-1)); end
            n_cmp++; if (dn1 !== (c == FRAME)) begin n_err++; $display("FAIL b2b_a_done c=%0d got %b want %b", c, dn1, (c == FRAME)); end
        end
        @(negedge clk);
        n_cmp++; if (sv1 !== 1'b0) begin n_err++; $display("FAIL b2b_gap_valid got %b want 0", sv1); end
        n_cmp++; if (sx1 !== 1'b0) begin n_err++; $display("FAIL b2b_gap_x got %b want 0", sx1); end
        n_cmp++; if (lr1 !== 1'b1) begin n_err++; $display("FAIL b2b_gap_ready got %b want 1", lr1); end
        @(posedge clk); #1;
        lv1 = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            n_cmp++; if (sx1 !== exp_bit(wb, c-1)) begin n_err++; $display("FAIL b2b_b_ser_x c=%0d got %b want %b", c, sx1, exp_bit(wb, c-1)); end
            n_cmp++; if (sv1 !== 1'b1) begin n_err++; $display("FAIL b2b_b_valid c=%0d got %b want 1", c, sv1); end
            n_cmp++; if (dn1 !== (c == FRAME)) begin n_err++; $display("FAIL b2b_b_done c=%0d got %b want %b", c, dn1, (c == FRAME)); end
        end
        @(negedge clk);
        n_cmp++; if (sv1 !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid got %b want 0", sv1); end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] w = 8'hA5;
        @(posedge clk); #1;
        lv1 = 1'b1; ld1 = w;
        @(posedge clk); #1;
        lv1 = 1'b0; ld1 = 8'hFF;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            n_cmp++; if (sx1 !== exp_bit(w, c-1)) begin n_err++; $display("FAIL ignore_ser_x c=%0d got %b want %b", c, sx1, exp_bit(w, c-1)); end
            n_cmp++; if (lr1 !== 1'b0) begin n_err++; $display("FAIL ignore_ready c=%0d got %b want 0", c, lr1); end
            if (c == 3) begin lv1 = 1'b1; ld1 = 8'h00; end
            if (c == 4) lv1 = 1'b0;
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_cmp++; if (sv1 !== 1'b0) begin n_err++; $display("FAIL ignore_idle_valid c=%0d got %b want 0", c, sv1); end
            n_cmp++; if (dn1 !== 1'b0) begin n_err++; $display("FAIL ignore_idle_done c=%0d got %b want 0", c, dn1); end
        end
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk); #1;
        lv1 = 1'b1; ld1 = 8'hFF;
        @(posedge clk); #1;
        lv1 = 1'b0;
        for (int c = 1; c <= 4; c++) @(negedge clk);
        n_cmp++; if (sx1 !== 1'b1) begin n_err++; $display("FAIL midrst_pre_x got %b want 1", sx1); end
        n_cmp++; if (sv1 !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid got %b want 1", sv1); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (sx1 !== 1'b0) begin n_err++; $display("FAIL midrst_x got %b want 0", sx1); end
        n_cmp++; if (sv1 !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", sv1); end
        n_cmp++; if (lr1 !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", lr1); end
        n_cmp++; if (dn1 !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", dn1); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            n_cmp++; if (dn1 !== 1'b0) begin n_err++; $display("FAIL midrst_after_done c=%0d got %b want 0", c, dn1); end
            n_cmp++; if (sv1 !== 1'b0) begin n_err++; $display("FAIL midrst_after_valid c=%0d got %b want 0", c, sv1); end
            n_cmp++; if (lr1 !== 1'b1) begin n_err++; $display("FAIL midrst_after_ready c=%0d got %b want 1", c, lr1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic(8'hA0);
        test_basic(8'h07);
        test_basic(8'h03);
        test_cpb3(8'hB5);
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
